// File: rtl/ieee754_pkg.sv
// ieee754_pkg: shared constants, FSM state type and operand struct for the
// single-precision accumulator.
package ieee754_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIG_W    = MAN_W + 4;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND
    } acc_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_unpacked_t;

    // Split a raw word into sign/exponent/significand; a zero exponent field
    // is flushed to a zero significand, so subnormals behave as zero.
    function automatic fp_unpacked_t unpack_fp(input logic [31:0] value);
        fp_unpacked_t u;
        u.sign = value[31];
        u.exp  = value[30:23];
        u.man  = (value[30:23] == 8'd0) ? 24'd0 : {1'b1, value[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// fp_align_shifter: right-shifts the smaller operand's 27-bit significand by
// the exponent difference, reporting any ones shifted out as a sticky bit.
module fp_align_shifter
    import ieee754_pkg::*;
(
    input  logic [SIG_W-1:0] din,
    input  logic [7:0]       shamt,
    output logic [SIG_W-1:0] dout,
    output logic             sticky
);

    logic [SIG_W-1:0] keep_mask;

    // Shift and collect lost bits; a shift of 27 or more leaves only the sticky
    always_comb begin
        keep_mask = '1;
        dout      = '0;
        sticky    = 1'b0;
        if (shamt >= 8'd27) begin
            dout   = '0;
            sticky = |din;
        end else begin
            keep_mask = {SIG_W{1'b1}} << shamt;
            dout      = din >> shamt;
            sticky    = |(din & ~keep_mask);
        end
    end

endmodule

// File: rtl/ieee_754_accumulator.sv
// ieee_754_accumulator: multi-cycle single-precision accumulator fed by the FP
// multiplier (acc <= acc + in_data), with a one-entry pending buffer.
// Build option: define IEEE754_ACC_RNE_EN for round-to-nearest-even; without
// it results are truncated toward zero.
module ieee_754_accumulator
    import ieee754_pkg::*;
#(
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        clear,
    output logic [31:0] acc,
    output logic        acc_valid,
    output logic        busy,
    output logic        overrun
);

    acc_state_t state, state_next;
    logic       start_op;

    logic [31:0] acc_q;
    logic        acc_valid_q;
    logic        overrun_q;
    logic        pend_full;
    logic [31:0] pend_data;

    logic [31:0] op_a;
    logic [31:0] op_b;

    logic             big_sign;
    logic             eff_sub;
    logic [9:0]       exp_q;
    logic [SIG_W-1:0] man_big;
    logic [SIG_W-1:0] man_small;
    logic             special_q;
    logic [31:0]      special_val;
    logic [SIG_W:0]   norm_man;
    logic             zero_q;

    fp_unpacked_t     ua, ub, op_big, op_small;
    logic             swap;
    logic [7:0]       exp_diff;
    logic             a_nan, b_nan, a_inf, b_inf;
    logic             special_c;
    logic [31:0]      special_c_val;
    logic [SIG_W-1:0] small_shifted;
    logic             small_sticky;

    logic [SIG_W:0]   add_sum;

    logic             round_up;
    logic [24:0]      round_sig;
    logic [9:0]       round_exp;
    logic [22:0]      round_frac;
    logic [31:0]      round_result;

    assign acc       = acc_q;
    assign acc_valid = acc_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state != IDLE) | pend_full;

    // Order the operands by magnitude and precompute any special-value result
    always_comb begin
        ua       = unpack_fp(op_a);
        ub       = unpack_fp(op_b);
        swap     = {ub.exp, ub.man} > {ua.exp, ua.man};
        op_big   = swap ? ub : ua;
        op_small = swap ? ua : ub;
        exp_diff = op_big.exp - op_small.exp;

        a_nan = (op_a[30:23] == EXP_INF) && (op_a[22:0] != 23'd0);
        b_nan = (op_b[30:23] == EXP_INF) && (op_b[22:0] != 23'd0);
        a_inf = (op_a[30:23] == EXP_INF) && (op_a[22:0] == 23'd0);
        b_inf = (op_b[30:23] == EXP_INF) && (op_b[22:0] == 23'd0);

        special_c     = (op_a[30:23] == EXP_INF) || (op_b[30:23] == EXP_INF);
        special_c_val = QNAN;
        if (a_nan || b_nan) begin
            special_c_val = QNAN;
        end else if (a_inf && b_inf) begin
            special_c_val = (op_a[31] != op_b[31]) ? QNAN : {op_a[31], EXP_INF, 23'd0};
        end else if (a_inf) begin
            special_c_val = {op_a[31], EXP_INF, 23'd0};
        end else if (b_inf) begin
            special_c_val = {op_b[31], EXP_INF, 23'd0};
        end
    end

    fp_align_shifter u_align_shifter (
        .din    ({op_small.man, 3'b000}),
        .shamt  (exp_diff),
        .dout   (small_shifted),
        .sticky (small_sticky)
    );

    // Magnitude add or subtract; the ordering above keeps subtraction non-negative
    always_comb begin
        if (eff_sub) begin
            add_sum = {1'b0, man_big} - {1'b0, man_small};
        end else begin
            add_sum = {1'b0, man_big} + {1'b0, man_small};
        end
    end

    // Round the normalised significand and pack it, saturating overflow to Inf
    always_comb begin
`ifdef IEEE754_ACC_RNE_EN
        round_up = norm_man[2] & (norm_man[1] | norm_man[0] | norm_man[3]);
`else
        round_up = 1'b0;
`endif
        round_sig  = {1'b0, norm_man[26:3]} + {24'd0, round_up};
        round_exp  = exp_q + {9'd0, round_sig[24]};
        round_frac = round_sig[24] ? round_sig[23:1] : round_sig[22:0];
        if (special_q) begin
            round_result = special_val;
        end else if (zero_q) begin
            round_result = 32'h0000_0000;
        end else if (round_exp >= 10'd255) begin
            round_result = {big_sign, EXP_INF, 23'd0};
        end else begin
            round_result = {big_sign, round_exp[7:0], round_frac};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; NORM leaves on the cycle of its last left shift, so an
    // operation needing k > 0 shifts takes 3 + k cycles before ROUND
    always_comb begin
        state_next = state;
        start_op   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_full || in_valid) begin
                    start_op   = 1'b1;
                    state_next = ALIGN;
                end
            end
            ALIGN: state_next = ADD;
            ADD: begin
                if (special_q || (add_sum == '0)) begin
                    state_next = ROUND;
                end else begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if (norm_man[27] || norm_man[26] || norm_man[25] || (exp_q <= 10'd1)) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (pend_full) begin
                    start_op   = 1'b1;
                    state_next = ALIGN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            start_op   = 1'b0;
            state_next = IDLE;
        end
    end

    // Accumulator, pending buffer and per-stage datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= ACC_INIT;
            acc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            pend_full   <= 1'b0;
            pend_data   <= '0;
            op_a        <= '0;
            op_b        <= '0;
            big_sign    <= 1'b0;
            eff_sub     <= 1'b0;
            exp_q       <= '0;
            man_big     <= '0;
            man_small   <= '0;
            special_q   <= 1'b0;
            special_val <= '0;
            norm_man    <= '0;
            zero_q      <= 1'b0;
        end else if (clear) begin
            acc_q       <= ACC_INIT;
            acc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            pend_full   <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;

            if (start_op) begin
                op_a <= (state == ROUND) ? round_result : acc_q;
                op_b <= pend_full ? pend_data : in_data;
            end

            if (start_op && pend_full) begin
                pend_full <= in_valid;
                if (in_valid) begin
                    pend_data <= in_data;
                end
            end else if (in_valid && (state != IDLE)) begin
                if (!pend_full) begin
                    pend_full <= 1'b1;
                    pend_data <= in_data;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state)
                ALIGN: begin
                    big_sign    <= op_big.sign;
                    eff_sub     <= op_big.sign ^ op_small.sign;
                    exp_q       <= {2'b00, op_big.exp};
                    man_big     <= {op_big.man, 3'b000};
                    man_small   <= {small_shifted[26:1], small_shifted[0] | small_sticky};
                    special_q   <= special_c;
                    special_val <= special_c_val;
                end
                ADD: begin
                    norm_man <= add_sum;
                    zero_q   <= (add_sum == '0);
                end
                NORM: begin
                    if (norm_man[27]) begin
                        norm_man <= {1'b0, norm_man[27:2], norm_man[1] | norm_man[0]};
                        exp_q    <= exp_q + 10'd1;
                    end else if (!norm_man[26]) begin
                        if (exp_q <= 10'd1) begin
                            zero_q <= 1'b1;
                        end else begin
                            norm_man <= {1'b0, norm_man[25:0], 1'b0};
                            exp_q    <= exp_q - 10'd1;
                        end
                    end
                end
                ROUND: begin
                    acc_q       <= round_result;
                    acc_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_754_accumulator.sv
// tb_ieee_754_accumulator: directed vectors with a scoreboard queue; the
// monitor pops an expected accumulator value on every acc_valid pulse.
module tb_ieee_754_accumulator;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        clear;
    logic [31:0] acc;
    logic        acc_valid;
    logic        busy;
    logic        overrun;

    int total;
    int bad;
    logic [31:0] sb_q[$];

    ieee_754_accumulator #(.ACC_INIT(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .clear     (clear),
        .acc       (acc),
        .acc_valid (acc_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: compare every acc_valid pulse against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && acc_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_acc_valid: got acc=%h expected no pulse", acc);
            end else begin
                checkOutput("acc_on_valid", acc, sb_q.pop_front());
            end
        end
    end

    // Issue one operand, wait for its result and optionally check latency/busy
    task automatic applyStimulus(input logic [31:0] data, input logic [31:0] expv, input int exp_lat);
        int  lat;
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        in_data  = data;
        in_valid = 1'b1;
        sb_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        busy_cnt = busy ? 1 : 0;
        seen     = 1'b0;
        lat      = 0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (acc_valid) begin
                seen = 1'b1;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL acc_valid_timeout: got no pulse within %0d cycles expected a pulse", lat);
        end else if (exp_lat > 0) begin
            checkOutput("latency", lat, exp_lat);
            checkOutput("busy_cycles", busy_cnt, exp_lat);
            checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        int waited;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        checkOutput("reset_acc", acc, 32'h0000_0000);
        checkOutput("reset_acc_valid", {31'd0, acc_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] basic add and cancellation");
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 4);
        applyStimulus(32'h4000_0000, 32'h4040_0000, -1);
        applyStimulus(32'hC040_0000, 32'h0000_0000, -1);

        $display("[TB] rounding");
        doClear();
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, -1);
`ifdef IEEE754_ACC_RNE_EN
        applyStimulus(32'h33C0_0000, 32'h3F80_0001, -1);
`else
        applyStimulus(32'h33C0_0000, 32'h3F80_0000, -1);
`endif

        $display("[TB] overflow and infinities");
        doClear();
        applyStimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, -1);
        applyStimulus(32'h7F7F_FFFF, 32'h7F80_0000, -1);
        applyStimulus(32'hFF80_0000, 32'h7FC0_0000, -1);

        $display("[TB] long normalisation");
        doClear();
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, -1);
        applyStimulus(32'hBF7F_FFFF, 32'h3380_0000, 27);

        $display("[TB] pending buffer and overrun");
        doClear();
        @(negedge clk);
        in_data  = 32'h3F80_0000;
        in_valid = 1'b1;
        sb_q.push_back(32'h3F80_0000);
        @(negedge clk);
        in_data  = 32'h4000_0000;
        sb_q.push_back(32'h4040_0000);
        @(negedge clk);
        in_data  = 32'h4080_0000;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        checkOutput("pending_drained", sb_q.size(), 32'd0);
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        checkOutput("acc_after_pending", acc, 32'h4040_0000);
        checkOutput("busy_after_pending", {31'd0, busy}, 32'd0);

        $display("[TB] clear during an operation");
        in_data  = 32'h3F80_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("clear_acc", acc, 32'h0000_0000);
        checkOutput("clear_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("clear_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge clk);

        $display("[TB] reset during normalisation");
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, -1);
        @(negedge clk);
        in_data  = 32'hBF7F_FFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_acc", acc, 32'h0000_0000);
        checkOutput("midop_reset_acc_valid", {31'd0, acc_valid}, 32'd0);
        checkOutput("midop_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midop_reset_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("idle_after_reset_acc", acc, 32'h0000_0000);
        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
